// File: rtl/cu_ctrl_pipe_pkg.sv
// Shared types for the control-word pipeline: select enums, the packed
// control word carried down the pipe, and its reset/bubble value.
package cu_ctrl_pipe_pkg;

    typedef enum logic [1:0] {
        ctrlDefault = 2'd0,
        ctrlJ       = 2'd1,
        ctrlJAL     = 2'd2,
        ctrlJR      = 2'd3
    } jctrl;

    typedef enum logic [1:0] {
        ctrlALURESULT = 2'd0,
        ctrlMEMDATA   = 2'd1,
        ctrlPC4       = 2'd2,
        ctrlLUI       = 2'd3
    } wctrl;

    typedef enum logic [1:0] {
        ctrlLSB     = 2'd0,
        ctrlSIGNEXT = 2'd1,
        ctrlZEROEXT = 2'd2,
        ctrlMSB     = 2'd3
    } ectrl;

    localparam int WDEST_W = 5;

    // 15-bit decoded control word
    typedef struct packed {
        jctrl               jsel;
        wctrl               wsel;
        ectrl               esel;
        logic               regwen;
        logic               dmemren;
        logic               dmemwen;
        logic               halt;
        logic [WDEST_W-1:0] wdest;
    } ctrl_word_t;

    localparam ctrl_word_t CTRL_NOP = '{
        jsel:    ctrlDefault,
        wsel:    ctrlALURESULT,
        esel:    ctrlLSB,
        regwen:  1'b0,
        dmemren: 1'b0,
        dmemwen: 1'b0,
        halt:    1'b0,
        wdest:   '0
    };

    // A load that writes a real register (r0 writes never create a hazard)
    function automatic logic isLoad(input ctrl_word_t c);
        return c.dmemren & c.regwen & (c.wdest != '0);
    endfunction

endpackage

// File: rtl/cu_ctrl_stage.sv
// One control pipeline register: flush beats hold, hold beats bubble,
// otherwise the stage loads from its predecessor (or from ID for stage 0).
module cu_ctrl_stage
    import cu_ctrl_pipe_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic       flush,
    input  logic       hold,
    input  logic       bubble,
    input  logic       prevValid,
    input  ctrl_word_t prevCtrl,
    output logic       valid,
    output ctrl_word_t ctrl
);

    // Stage register update; the ctrl word is left untouched on flush/bubble
    // since it is ignored whenever valid is low.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid <= 1'b0;
            ctrl  <= CTRL_NOP;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (!hold) begin
            if (bubble) begin
                valid <= 1'b0;
            end else begin
                valid <= prevValid;
                ctrl  <= prevCtrl;
            end
        end
    end

endmodule

// File: rtl/cu_ctrl_pipe.sv
// Control-word pipeline for the pipelined MIPS core: carries the decoded
// control word from ID through STAGES registers, with per-stage stall and
// flush, load-use bubble insertion, jump redirect and a sticky halt.
module cu_ctrl_pipe
    import cu_ctrl_pipe_pkg::*;
#(
    parameter int STAGES = 3,
    parameter int REGW   = 5,
    parameter int JSTAGE = 0
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     in_valid,
    input  ctrl_word_t               in_ctrl,
    input  logic [REGW-1:0]          in_rs,
    input  logic [REGW-1:0]          in_rt,
    output logic                     in_ready,
    input  logic [STAGES-1:0]        stall,
    input  logic [STAGES-1:0]        flush,
    output logic [STAGES-1:0]        st_valid,
    output ctrl_word_t [STAGES-1:0]  st_ctrl,
    output logic                     lu_hazard,
    output logic                     redirect,
    output jctrl                     redirect_sel,
    output logic                     halted
);

    logic [STAGES-1:0] holdVec;
    logic [STAGES-1:0] flushEff;
    logic              redirKill;
    logic              inTake;

    // Effective hold: a stalled stage freezes itself and every younger stage
    always_comb begin
        holdVec = '0;
        for (int i = 0; i < STAGES; i++) begin
            holdVec[i] = |(stall >> i);
        end
    end

    assign lu_hazard = in_valid & st_valid[0] & isLoad(st_ctrl[0])
                     & ((REGW'(st_ctrl[0].wdest) == in_rs) | (REGW'(st_ctrl[0].wdest) == in_rt));

    assign redirect     = st_valid[JSTAGE] & (st_ctrl[JSTAGE].jsel != ctrlDefault) & ~flush[JSTAGE];
    assign redirect_sel = redirect ? st_ctrl[JSTAGE].jsel : ctrlDefault;

    assign in_ready = ~holdVec[0] & ~lu_hazard & ~halted;

    // Younger instructions are killed only on the edge where the jump itself
    // moves on; while it is held they are held too and the redirect persists.
    assign redirKill = redirect & ~holdVec[JSTAGE];
    assign inTake    = in_valid & in_ready & ~redirect;

    // Squash the registers that would receive the instructions currently in
    // stages 0..JSTAGE-1 (i.e. stages 1..JSTAGE); the ID input is gated above.
    always_comb begin
        flushEff = flush;
        for (int i = 1; i < STAGES; i++) begin
            if (i <= JSTAGE) begin
                flushEff[i] = flush[i] | redirKill;
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : gStage
        if (g == 0) begin : gFirst
            cu_ctrl_stage uStage (
                .CLK       (CLK),
                .RST       (RST),
                .flush     (flushEff[0]),
                .hold      (holdVec[0]),
                .bubble    (1'b0),
                .prevValid (inTake),
                .prevCtrl  (in_ctrl),
                .valid     (st_valid[0]),
                .ctrl      (st_ctrl[0])
            );
        end else begin : gRest
            cu_ctrl_stage uStage (
                .CLK       (CLK),
                .RST       (RST),
                .flush     (flushEff[g]),
                .hold      (holdVec[g]),
                .bubble    (holdVec[g-1]),
                .prevValid (st_valid[g-1]),
                .prevCtrl  (st_ctrl[g-1]),
                .valid     (st_valid[g]),
                .ctrl      (st_ctrl[g])
            );
        end
    end

    // Sticky halt once a halt word sits valid in the last stage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halted <= 1'b0;
        end else if (st_valid[STAGES-1] & st_ctrl[STAGES-1].halt) begin
            halted <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cu_ctrl_pipe.sv
// Directed bench for cu_ctrl_pipe: a default instance (STAGES=3, JSTAGE=0)
// and a deeper one (STAGES=5, JSTAGE=2) sharing clock and reset.
module tb_cu_ctrl_pipe;
    import cu_ctrl_pipe_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Instance A: defaults
    logic            aInValid;
    ctrl_word_t      aInCtrl;
    logic [4:0]      aRs, aRt;
    logic            aReady;
    logic [2:0]      aStall, aFlush, aValid;
    ctrl_word_t [2:0] aCtrl;
    logic            aHaz, aRedir, aHalted;
    jctrl            aRedirSel;

    // Instance B: deeper pipe, late jump resolution
    logic            bInValid;
    ctrl_word_t      bInCtrl;
    logic [4:0]      bRs, bRt;
    logic            bReady;
    logic [4:0]      bStall, bFlush, bValid;
    ctrl_word_t [4:0] bCtrl;
    logic            bHaz, bRedir, bHalted;
    jctrl            bRedirSel;

    cu_ctrl_pipe #(.STAGES(3), .REGW(5), .JSTAGE(0)) uDutA (
        .CLK(CLK), .RST(RST), .in_valid(aInValid), .in_ctrl(aInCtrl), .in_rs(aRs), .in_rt(aRt),
        .in_ready(aReady), .stall(aStall), .flush(aFlush), .st_valid(aValid), .st_ctrl(aCtrl),
        .lu_hazard(aHaz), .redirect(aRedir), .redirect_sel(aRedirSel), .halted(aHalted)
    );

    cu_ctrl_pipe #(.STAGES(5), .REGW(5), .JSTAGE(2)) uDutB (
        .CLK(CLK), .RST(RST), .in_valid(bInValid), .in_ctrl(bInCtrl), .in_rs(bRs), .in_rt(bRt),
        .in_ready(bReady), .stall(bStall), .flush(bFlush), .st_valid(bValid), .st_ctrl(bCtrl),
        .lu_hazard(bHaz), .redirect(bRedir), .redirect_sel(bRedirSel), .halted(bHalted)
    );

    function automatic ctrl_word_t mk(input jctrl j, input wctrl w, input logic rw,
                                      input logic dr, input logic ht, input logic [4:0] wd);
        ctrl_word_t c;
        c         = CTRL_NOP;
        c.jsel    = j;
        c.wsel    = w;
        c.regwen  = rw;
        c.dmemren = dr;
        c.halt    = ht;
        c.wdest   = wd;
        return c;
    endfunction

    function automatic logic [31:0] w32(input ctrl_word_t c);
        return {17'd0, c};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #2;
    endtask

    ctrl_word_t A1, A2, A3, L8, U8, L0, U0, B1, B2, B3, B4, J, JR, H, D1, D2, D3, D4, D5, E1, K1, K2, K3;

    initial begin
        A1 = mk(ctrlDefault, ctrlALURESULT, 1'b1, 1'b0, 1'b0, 5'd1);
        A2 = mk(ctrlDefault, ctrlALURESULT, 1'b1, 1'b0, 1'b0, 5'd2);
        A3 = mk(ctrlDefault, ctrlALURESULT, 1'b1, 1'b0, 1'b0, 5'd3);
        L8 = mk(ctrlDefault, ctrlMEMDATA,   1'b1, 1'b1, 1'b0, 5'd8);
        U8 = mk(ctrlDefault, ctrlALURESULT, 1'b1, 1'b0, 1'b0, 5'd9);
        L0 = mk(ctrlDefault, ctrlMEMDATA,   1'b1, 1'b1, 1'b0, 5'd0);
        U0 = mk(ctrlDefault, ctrlALURESULT, 1'b1, 1'b0, 1'b0, 5'd10);
        B1 = mk(ctrlDefault, ctrlALURESULT, 1'b1, 1'b0, 1'b0, 5'd11);
        B2 = mk(ctrlDefault, ctrlALURESULT, 1'b1, 1'b0, 1'b0, 5'd12);
        B3 = mk(ctrlDefault, ctrlALURESULT, 1'b1, 1'b0, 1'b0, 5'd13);
        B4 = mk(ctrlDefault, ctrlALURESULT, 1'b1, 1'b0, 1'b0, 5'd14);
        J  = mk(ctrlJ,       ctrlALURESULT, 1'b0, 1'b0, 1'b0, 5'd0);
        JR = mk(ctrlJR,      ctrlALURESULT, 1'b0, 1'b0, 1'b0, 5'd0);
        H  = mk(ctrlDefault, ctrlALURESULT, 1'b0, 1'b0, 1'b1, 5'd0);
        D1 = mk(ctrlDefault, ctrlPC4,       1'b1, 1'b0, 1'b0, 5'd21);
        D2 = mk(ctrlDefault, ctrlPC4,       1'b1, 1'b0, 1'b0, 5'd22);
        D3 = mk(ctrlDefault, ctrlPC4,       1'b1, 1'b0, 1'b0, 5'd23);
        D4 = mk(ctrlDefault, ctrlPC4,       1'b1, 1'b0, 1'b0, 5'd24);
        D5 = mk(ctrlDefault, ctrlPC4,       1'b1, 1'b0, 1'b0, 5'd25);
        E1 = mk(ctrlDefault, ctrlLUI,       1'b1, 1'b0, 1'b0, 5'd26);
        K1 = mk(ctrlDefault, ctrlLUI,       1'b1, 1'b0, 1'b0, 5'd27);
        K2 = mk(ctrlDefault, ctrlLUI,       1'b1, 1'b0, 1'b0, 5'd28);
        K3 = mk(ctrlDefault, ctrlLUI,       1'b1, 1'b0, 1'b0, 5'd29);

        aInValid = 0; aInCtrl = CTRL_NOP; aRs = 0; aRt = 0; aStall = 0; aFlush = 0;
        bInValid = 0; bInCtrl = CTRL_NOP; bRs = 0; bRt = 0; bStall = 0; bFlush = 0;

        // Reset state
        repeat (2) @(posedge CLK);
        #2;
        chk("rst_a_valid", 32'(aValid), 32'd0);
        chk("rst_b_valid", 32'(bValid), 32'd0);
        chk("rst_a_halted", 32'(aHalted), 32'd0);
        for (int i = 0; i < 3; i++) chk("rst_a_ctrl", w32(aCtrl[i]), w32(CTRL_NOP));
        for (int i = 0; i < 5; i++) chk("rst_b_ctrl", w32(bCtrl[i]), w32(CTRL_NOP));
        chk("rst_a_redir_sel", 32'(aRedirSel), 32'(ctrlDefault));
        RST = 0;

        // Three ALU words flow through unstalled
        aInValid = 1; aInCtrl = A1;
        #1 chk("flow_ready", 32'(aReady), 32'd1);
        cyc();
        chk("flow_v1", 32'(aValid), 32'b001);
        chk("flow_c1_s0", w32(aCtrl[0]), w32(A1));
        aInCtrl = A2; cyc();
        chk("flow_v2", 32'(aValid), 32'b011);
        chk("flow_c2_s1", w32(aCtrl[1]), w32(A1));
        aInCtrl = A3; cyc();
        chk("flow_v3", 32'(aValid), 32'b111);
        chk("flow_c3_s2", w32(aCtrl[2]), w32(A1));
        chk("flow_c3_s1", w32(aCtrl[1]), w32(A2));
        chk("flow_c3_s0", w32(aCtrl[0]), w32(A3));

        // Load-use hazard on wdest=8
        aInCtrl = L8; cyc();
        aInCtrl = U8; aRs = 5'd8;
        #1;
        chk("lu_hazard", 32'(aHaz), 32'd1);
        chk("lu_ready", 32'(aReady), 32'd0);
        cyc();
        chk("lu_bubble_v", 32'(aValid), 32'b110);
        chk("lu_load_s1", w32(aCtrl[1]), w32(L8));
        chk("lu_cleared", 32'(aHaz), 32'd0);
        chk("lu_ready2", 32'(aReady), 32'd1);
        cyc();
        chk("lu_accept_v", 32'(aValid), 32'b101);
        chk("lu_accept_s0", w32(aCtrl[0]), w32(U8));
        chk("lu_load_s2", w32(aCtrl[2]), w32(L8));

        // Load to r0 never hazards
        aInCtrl = L0; aRs = 0; aRt = 0; cyc();
        aInCtrl = U0;
        #1;
        chk("lu0_hazard", 32'(aHaz), 32'd0);
        chk("lu0_ready", 32'(aReady), 32'd1);
        cyc();
        chk("lu0_s1", w32(aCtrl[1]), w32(L0));
        chk("lu0_s0", w32(aCtrl[0]), w32(U0));

        // Stall stage 1 for two cycles with the pipe full
        aInCtrl = B1; cyc();
        aInCtrl = B2; cyc();
        aInCtrl = B3; cyc();
        chk("st_full", 32'(aValid), 32'b111);
        aStall = 3'b010; aInCtrl = B4;
        #1 chk("st_ready", 32'(aReady), 32'd0);
        cyc();
        chk("st_v1", 32'(aValid), 32'b011);
        chk("st_s0_frozen", w32(aCtrl[0]), w32(B3));
        chk("st_s1_frozen", w32(aCtrl[1]), w32(B2));
        cyc();
        chk("st_v2", 32'(aValid), 32'b011);
        aStall = 0;
        #1 chk("st_ready_resume", 32'(aReady), 32'd1);
        cyc();
        chk("st_resume_v", 32'(aValid), 32'b111);
        chk("st_resume_s2", w32(aCtrl[2]), w32(B2));
        chk("st_resume_s0", w32(aCtrl[0]), w32(B4));
        aInValid = 0; cyc();
        chk("st_drain_v", 32'(aValid), 32'b110);
        chk("st_drain_s2", w32(aCtrl[2]), w32(B3));

        // Jump at stage 0 squashes the younger ID input
        aInValid = 1; aInCtrl = J; cyc();
        aInCtrl = B1;
        #1;
        chk("rd_redirect", 32'(aRedir), 32'd1);
        chk("rd_sel", 32'(aRedirSel), 32'(ctrlJ));
        cyc();
        chk("rd_squash_v0", 32'(aValid[0]), 32'd0);
        chk("rd_j_s1", w32(aCtrl[1]), w32(J));
        chk("rd_done", 32'(aRedir), 32'd0);
        chk("rd_done_sel", 32'(aRedirSel), 32'(ctrlDefault));
        aInCtrl = J; cyc();
        aFlush = 3'b001; aInCtrl = B2;
        #1;
        chk("rdf_redirect", 32'(aRedir), 32'd0);
        chk("rdf_sel", 32'(aRedirSel), 32'(ctrlDefault));
        cyc();
        chk("rdf_flush_v0", 32'(aValid[0]), 32'd0);
        aFlush = 0; aInValid = 0;

        // Halt retires at stage 2
        aInValid = 1; aInCtrl = H; cyc();
        aInValid = 0; cyc();
        cyc();
        chk("h_at_s2", 32'(aValid[2]), 32'd1);
        chk("h_not_yet", 32'(aHalted), 32'd0);
        cyc();
        chk("h_set", 32'(aHalted), 32'd1);
        aInValid = 1; aInCtrl = B1;
        #1 chk("h_ready", 32'(aReady), 32'd0);
        cyc();
        chk("h_ignored", 32'(aValid[0]), 32'd0);
        cyc();
        chk("h_sticky", 32'(aHalted), 32'd1);
        aInValid = 0;
        RST = 1;
        #1 chk("h_rst", 32'(aHalted), 32'd0);
        RST = 0;

        // Deep instance: fill, check latency and ordering
        bInValid = 1; bInCtrl = D1; cyc();
        chk("b_v1", 32'(bValid), 32'b00001);
        bInCtrl = D2; cyc();
        bInCtrl = D3; cyc();
        bInCtrl = D4; cyc();
        bInCtrl = D5; cyc();
        chk("b_full", 32'(bValid), 32'b11111);
        chk("b_s4", w32(bCtrl[4]), w32(D1));
        chk("b_s2", w32(bCtrl[2]), w32(D3));
        chk("b_s0", w32(bCtrl[0]), w32(D5));

        // Stall stage 2: stages 0..2 freeze, stage 3 bubbles, stage 4 drains
        bStall = 5'b00100; bInCtrl = E1;
        #1 chk("b_st_ready", 32'(bReady), 32'd0);
        cyc();
        chk("b_st_v1", 32'(bValid), 32'b10111);
        chk("b_st_s4", w32(bCtrl[4]), w32(D2));
        chk("b_st_s2", w32(bCtrl[2]), w32(D3));
        cyc();
        chk("b_st_v2", 32'(bValid), 32'b00111);
        bStall = 0; cyc();
        chk("b_st_resume_v", 32'(bValid), 32'b01111);
        chk("b_st_resume_s3", w32(bCtrl[3]), w32(D3));
        chk("b_st_resume_s0", w32(bCtrl[0]), w32(E1));
        bInValid = 0;
        repeat (5) cyc();
        chk("b_drained", 32'(bValid), 32'd0);

        // Redirect at stage 2 squashes stages 0, 1 and the input
        bInValid = 1; bInCtrl = JR; cyc();
        chk("b_rd_early", 32'(bRedir), 32'd0);
        bInCtrl = K1; cyc();
        bInCtrl = K2; cyc();
        bInCtrl = K3;
        #1;
        chk("b_rd_redirect", 32'(bRedir), 32'd1);
        chk("b_rd_sel", 32'(bRedirSel), 32'(ctrlJR));
        cyc();
        chk("b_rd_v", 32'(bValid), 32'b01000);
        chk("b_rd_s3", w32(bCtrl[3]), w32(JR));
        chk("b_rd_done", 32'(bRedir), 32'd0);
        bInValid = 0;

        // Asynchronous reset mid-cycle with a full pipe
        aInValid = 1; aInCtrl = A1; cyc();
        aInCtrl = A2; cyc();
        aInCtrl = A3; cyc();
        aInValid = 0;
        chk("ar_full", 32'(aValid), 32'b111);
        #3 RST = 1;
        #1;
        chk("ar_valid", 32'(aValid), 32'd0);
        for (int i = 0; i < 3; i++) chk("ar_ctrl", w32(aCtrl[i]), w32(CTRL_NOP));
        RST = 0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
